// File: rtl/pin_test_sequencer_pkg.sv
// Shared phase codes, widths and sizing helpers
// for the pin bank self-test sequencer.
package pin_test_pkg;

    localparam int PHASE_W = 3;
    localparam int IDX_W   = 6;

    typedef enum logic [PHASE_W-1:0] {
        IDLE    = 3'd0,
        ALL_ON  = 3'd1,
        ALL_OFF = 3'd2,
        WALK1   = 3'd3,
        WALK0   = 3'd4,
        DONE    = 3'd5
    } phase_e;

    // A one-cycle dwell still needs a 1-bit counter.
    function automatic int cnt_w(input int d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/pin_test_sequencer_dwell_timer.sv
// Step dwell counter: counts 0..DWELL-1 while enabled,
// pulses tick on the last count and wraps to zero.
module dwell_timer
    import pin_test_pkg::*;
#(
    parameter int DWELL = 12000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pin_test_sequencer.sv
// Timed, restartable self-test scan over the output pin bank:
// all on, all off, walking one, walking zero.
module pin_test_sequencer
    import pin_test_pkg::*;
#(
    parameter int NUM_PINS = 40,
    parameter int DWELL    = 12000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                hold,
    input  logic                loop_en,
    output logic [NUM_PINS-1:0] pins,
    output logic                busy,
    output logic                done,
    output logic [PHASE_W-1:0]  phase,
    output logic [IDX_W-1:0]    pin_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);

    phase_e              state;
    phase_e              state_d;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_d;
    logic [NUM_PINS-1:0] pins_d;
    logic                busy_d;
    logic                done_d;
    logic                active;
    logic                en;
    logic                clr;
    logic                tick;
    logic                last;

    assign active = (state == ALL_ON) || (state == ALL_OFF)
                 || (state == WALK1)  || (state == WALK0);
    assign en     = active && !hold && !abort;
    assign clr    = abort || !active;
    assign last   = (idx == LAST_IDX);

    dwell_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = ALL_ON;
                        idx_d   = '0;
                    end
                end
                ALL_ON: begin
                    if (tick) state_d = ALL_OFF;
                end
                ALL_OFF: begin
                    if (tick) begin
                        state_d = WALK1;
                        idx_d   = '0;
                    end
                end
                WALK1: begin
                    if (tick) begin
                        if (last) begin
                            state_d = WALK0;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end
                end
                WALK0: begin
                    if (tick) begin
                        if (last) begin
                            state_d = loop_en ? ALL_ON : DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Decode from the next state so the pattern lands with the phase.
    always_comb begin
        pins_d = '0;
        busy_d = 1'b0;
        done_d = 1'b0;
        unique case (1'b1)
            state_d == ALL_ON: begin
                pins_d = '1;
                busy_d = 1'b1;
            end
            state_d == ALL_OFF: begin
                busy_d = 1'b1;
            end
            state_d == WALK1: begin
                pins_d = NUM_PINS'(1) << idx_d;
                busy_d = 1'b1;
            end
            state_d == WALK0: begin
                pins_d = ~(NUM_PINS'(1) << idx_d);
                busy_d = 1'b1;
            end
            state_d == DONE: begin
                done_d = 1'b1;
            end
            default: begin
                pins_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pins <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            pins <= pins_d;
            busy <= busy_d;
            done <= done_d;
        end
    end

    assign phase   = state;
    assign pin_idx = idx;

endmodule

// File: tb/tb_pin_test_sequencer.sv
// Directed bench: 4-pin/3-cycle scan plus a 1-pin/1-cycle
// corner instance sharing clock and reset.
module tb_pin_test_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic       loop_en = 1'b0;
    logic [3:0] pins;
    logic       busy;
    logic       done;
    logic [2:0] phase;
    logic [5:0] pin_idx;

    logic       start1 = 1'b0;
    logic       abort1 = 1'b0;
    logic       hold1 = 1'b0;
    logic       loop1 = 1'b0;
    logic [0:0] pins1;
    logic       busy1;
    logic       done1;
    logic [2:0] phase1;
    logic [5:0] idx1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pin_test_sequencer #(
        .NUM_PINS (4),
        .DWELL    (3)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .hold    (hold),
        .loop_en (loop_en),
        .pins    (pins),
        .busy    (busy),
        .done    (done),
        .phase   (phase),
        .pin_idx (pin_idx)
    );

    pin_test_sequencer #(
        .NUM_PINS (1),
        .DWELL    (1)
    ) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .abort   (abort1),
        .hold    (hold1),
        .loop_en (loop1),
        .pins    (pins1),
        .busy    (busy1),
        .done    (done1),
        .phase   (phase1),
        .pin_idx (idx1)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    logic [3:0] exp_pins [10] = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h4,
                                  4'h8, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [2:0] exp_ph   [10] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3,
                                  3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    logic [5:0] exp_idx  [10] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd2,
                                  6'd3, 6'd0, 6'd1, 6'd2, 6'd3};

    initial begin
        logic saw_done;
        step(2);
        check("rst_pins", 64'(pins), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_phase", 64'(phase), 64'h0);
        check("rst_idx", 64'(pin_idx), 64'h0);
        rst_n = 1'b1;
        step();
        check("idle_pins", 64'(pins), 64'h0);

        // full pass: 30 cycles then DONE
        kick();
        for (int c = 0; c < 30; c++) begin
            check($sformatf("scan_pins_%0d", c), 64'(pins),
                  64'(exp_pins[c / 3]));
            check($sformatf("scan_ph_%0d", c), 64'(phase),
                  64'(exp_ph[c / 3]));
            check($sformatf("scan_idx_%0d", c), 64'(pin_idx),
                  64'(exp_idx[c / 3]));
            check($sformatf("scan_busy_%0d", c), 64'(busy), 64'h1);
            step();
        end
        check("done_pins", 64'(pins), 64'h0);
        check("done_done", 64'(done), 64'h1);
        check("done_busy", 64'(busy), 64'h0);
        check("done_phase", 64'(phase), 64'h5);
        step(2);
        check("done_sticky", 64'(done), 64'h1);

        // looping from DONE
        loop_en = 1'b1;
        kick();
        check("loop_done_clr", 64'(done), 64'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (done) saw_done = 1'b1;
            if (c == 29) check("loop_last", 64'(pins), 64'h7);
            step();
        end
        check("loop_phase", 64'(phase), 64'h1);
        check("loop_pins", 64'(pins), 64'hF);
        check("loop_nodone", 64'(saw_done), 64'h0);
        step(30);
        check("loop2_phase", 64'(phase), 64'h1);
        do_abort();
        loop_en = 1'b0;
        check("abort_loop", 64'(phase), 64'h0);

        // hold in the middle of the 0010 step
        kick();
        step(9);
        check("hold_c9", 64'(pins), 64'h2);
        step();
        check("hold_c10", 64'(pins), 64'h2);
        hold = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("hold_frz_%0d", c), 64'(pins), 64'h2);
            check($sformatf("hold_idx_%0d", c), 64'(pin_idx), 64'h1);
        end
        hold = 1'b0;
        step();
        check("hold_c16", 64'(pins), 64'h2);
        step();
        check("hold_next", 64'(pins), 64'h4);
        check("hold_next_idx", 64'(pin_idx), 64'h2);
        do_abort();

        // abort during WALK0 idx 2, then restart
        kick();
        step(25);
        check("ab_pre_idx", 64'(pin_idx), 64'h2);
        check("ab_pre_pins", 64'(pins), 64'hB);
        do_abort();
        check("ab_pins", 64'(pins), 64'h0);
        check("ab_phase", 64'(phase), 64'h0);
        check("ab_busy", 64'(busy), 64'h0);
        check("ab_idx", 64'(pin_idx), 64'h0);
        kick();
        check("re_phase", 64'(phase), 64'h1);
        check("re_pins", 64'(pins), 64'hF);
        step(3);
        check("re_step", 64'(phase), 64'h2);
        do_abort();

        // start with abort in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("sa_phase", 64'(phase), 64'h0);
        check("sa_busy", 64'(busy), 64'h0);

        // start while busy is ignored
        kick();
        step(4);
        kick();
        check("sb_c5_ph", 64'(phase), 64'h2);
        check("sb_c5_pins", 64'(pins), 64'h0);
        step();
        check("sb_c6_ph", 64'(phase), 64'h3);
        check("sb_c6_pins", 64'(pins), 64'h1);
        do_abort();

        // async reset between edges
        kick();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_pins", 64'(pins), 64'h0);
        check("ar_busy", 64'(busy), 64'h0);
        check("ar_phase", 64'(phase), 64'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("ar_idle", 64'(phase), 64'h0);
        kick();
        check("ar_restart", 64'(pins), 64'hF);
        step(3);
        check("ar_step", 64'(phase), 64'h2);
        do_abort();

        // one pin, one-cycle dwell
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("p1_on", 64'(pins1), 64'h1);
        check("p1_on_ph", 64'(phase1), 64'h1);
        step();
        check("p1_off", 64'(pins1), 64'h0);
        check("p1_off_ph", 64'(phase1), 64'h2);
        step();
        check("p1_w1", 64'(pins1), 64'h1);
        check("p1_w1_ph", 64'(phase1), 64'h3);
        step();
        check("p1_w0", 64'(pins1), 64'h0);
        check("p1_w0_ph", 64'(phase1), 64'h4);
        step();
        check("p1_done_ph", 64'(phase1), 64'h5);
        check("p1_done", 64'(done1), 64'h1);
        check("p1_busy", 64'(busy1), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
